pokey_bus_master: RTL

Bus initiator that drives the CPU-side register interface of the POKEY sound block from a simple valid/ready request stream. It generates a free-running phi2, queues register reads and writes in a small FIFO, and launches one access per phi2 period with `cs0Bar`, `readHighWriteLow`, `A` and `Din` held stable across the whole period. Read data is returned on a pulsed response port. It sits between a sound-command sequencer or soft-CPU stub and the POKEY instance.

---
 rtl/pokey_pkg.sv | 48 ++++
 rtl/pokey_req_fifo.sv | 60 ++++++
 rtl/pokey_bus_master.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pokey_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pokey_pkg
// Purpose  : POKEY register map, bus request record and master FSM encoding.
// Revision : 1.0  initial release
// ============================================================================
package pokey_pkg;

   // Write-side register map
   localparam logic [3:0] AUDF1  = 4'h0;
   localparam logic [3:0] AUDC1  = 4'h1;
   localparam logic [3:0] AUDF2  = 4'h2;
   localparam logic [3:0] AUDC2  = 4'h3;
   localparam logic [3:0] AUDF3  = 4'h4;
   localparam logic [3:0] AUDC3  = 4'h5;
   localparam logic [3:0] AUDF4  = 4'h6;
   localparam logic [3:0] AUDC4  = 4'h7;
   localparam logic [3:0] AUDCTL = 4'h8;
   localparam logic [3:0] POTGO  = 4'hB;
   localparam logic [3:0] SKCTL  = 4'hF;

   // Read-side registers sharing the same decode
   localparam logic [3:0] ALLPOT = 4'h8;
   localparam logic [3:0] RANDOM = 4'hA;

   typedef struct packed {
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
   } pokey_req_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } pokey_state_t;

   function automatic pokey_req_t make_req(input logic write,
                                           input logic [3:0] addr,
                                           input logic [7:0] wdata);
      pokey_req_t r;
      r.write = write;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pokey_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pokey_req_fifo
// Purpose  : Registered FIFO of POKEY requests with full/empty flags.
// Revision : 1.0  initial release
// ============================================================================
module pokey_req_fifo
   import pokey_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       clrBar,
   input  logic       i_push,
   input  pokey_req_t i_din,
   output logic       o_full,
   input  logic       i_pop,
   output pokey_req_t o_dout,
   output logic       o_empty
);

   localparam int c_AW = $clog2(DEPTH);

   pokey_req_t       r_mem [DEPTH];
   logic [c_AW:0]    r_wptr;
   logic [c_AW:0]    r_rptr;
   logic             w_push;
   logic             w_pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop  & ~o_empty;
   assign o_dout  = r_mem[r_rptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[c_AW-1:0]] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge clrBar) begin
      if (!clrBar) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pokey_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : pokey_bus_master
// Purpose  : Drives the POKEY CPU bus, one queued access per phi2 period.
// Revision : 1.0  initial release
// ============================================================================
module pokey_bus_master
   import pokey_pkg::*;
#(
   parameter int PHI2_HALF = 28,
   parameter int DEPTH     = 4
) (
   input  logic       clk,
   input  logic       clrBar,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       phi2,
   output logic       cs0Bar,
   output logic       readHighWriteLow,
   output logic [3:0] A,
   output logic [7:0] Din,
   input  logic [7:0] Dout
);

   localparam int               c_PHW     = $clog2(PHI2_HALF);
   localparam logic [c_PHW-1:0] c_PH_LAST = c_PHW'(PHI2_HALF - 1);

   logic [c_PHW-1:0] r_ph_cnt;
   logic             r_phi2;
   logic             w_fall_tick;

   pokey_state_t     r_state, w_state_nxt;
   logic             r_cs0_n, w_cs0_n_nxt;
   logic             r_rhwl, w_rhwl_nxt;
   logic [3:0]       r_a, w_a_nxt;
   logic [7:0]       r_din, w_din_nxt;
   logic             r_rsp_valid, w_rsp_valid_nxt;
   logic [7:0]       r_rsp_rdata, w_rsp_rdata_nxt;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   pokey_req_t       w_head;

   always_ff @(posedge clk or negedge clrBar) begin
      if (!clrBar) begin
         r_ph_cnt <= '0;
         r_phi2   <= 1'b0;
      end else if (r_ph_cnt == c_PH_LAST) begin
         r_ph_cnt <= '0;
         r_phi2   <= ~r_phi2;
      end else begin
         r_ph_cnt <= r_ph_cnt + 1'b1;
      end
   end

   // Edge on which phi2 goes low: the only edge the bus may change
   assign w_fall_tick = (r_ph_cnt == c_PH_LAST) & r_phi2;

   pokey_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clrBar  (clrBar),
      .i_push  (req_valid),
      .i_din   (make_req(req_write, req_addr, req_wdata)),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge clrBar) begin
      if (!clrBar) begin
         r_state     <= ST_IDLE;
         r_cs0_n     <= 1'b1;
         r_rhwl      <= 1'b1;
         r_a         <= 4'h0;
         r_din       <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_cs0_n     <= w_cs0_n_nxt;
         r_rhwl      <= w_rhwl_nxt;
         r_a         <= w_a_nxt;
         r_din       <= w_din_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cs0_n_nxt     = r_cs0_n;
      w_rhwl_nxt      = r_rhwl;
      w_a_nxt         = r_a;
      w_din_nxt       = r_din;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_pop           = 1'b0;

      if (w_fall_tick) begin
         // Complete the access that has been on the bus for a full period
         if ((r_state == ST_ACCESS) && r_rhwl) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = Dout;
         end

         if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_ACCESS;
            w_cs0_n_nxt = 1'b0;
            w_rhwl_nxt  = ~w_head.write;
            w_a_nxt     = w_head.addr;
            w_din_nxt   = w_head.write ? w_head.wdata : 8'h00;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cs0_n_nxt = 1'b1;
            w_rhwl_nxt  = 1'b1;
            w_a_nxt     = 4'h0;
            w_din_nxt   = 8'h00;
         end
      end
   end

   assign req_ready        = ~w_full;
   assign busy             = (r_state == ST_ACCESS) | ~w_empty;
   assign phi2             = r_phi2;
   assign cs0Bar           = r_cs0_n;
   assign readHighWriteLow = r_rhwl;
   assign A                = r_a;
   assign Din              = r_din;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_rdata        = r_rsp_rdata;

endmodule
`default_nettype wire
